// File: rtl/cordic_sincos.sv
`default_nettype none
// ============================================================================
// Module  : cordic_sincos
// Brief   : Iterative CORDIC engine producing sine and cosine of a binary angle.
// Revision: 1.0
// ============================================================================
module cordic_sincos #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 28,
    parameter int GUARD      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] angle,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sin,
    output logic [WIDTH-1:0] cos
);

    localparam int c_XW = WIDTH + GUARD + 1;
    localparam int c_ZW = WIDTH + GUARD;
    localparam int c_IW = $clog2(ITERATIONS + 1);
    localparam int c_P  = 90;
    localparam int c_CW = 200;

    // Fixed-point atan(1/m) scaled by 2^c_P, used to build pi (Machin).
    function automatic logic [c_CW-1:0] atan_inv(input int m);
        logic [c_CW-1:0] pw;
        logic [c_CW-1:0] acc;
        int              n;
        pw  = (c_CW'(1) << c_P) / c_CW'(m);
        acc = '0;
        n   = 0;
        while (pw != '0) begin
            if ((n % 2) == 0) acc = acc + pw / c_CW'(2 * n + 1);
            else              acc = acc - pw / c_CW'(2 * n + 1);
            pw = pw / c_CW'(m * m);
            n  = n + 1;
        end
        return acc;
    endfunction

    localparam logic [c_CW-1:0] c_PI = (atan_inv(5) << 4) - (atan_inv(239) << 2);

    function automatic logic [c_CW-1:0] atan_pow2(input int i);
        logic [c_CW-1:0] acc;
        int              n;
        int              e;
        if (i == 0) return c_PI >> 2;
        acc = '0;
        n   = 0;
        e   = c_P - i;
        while (e >= 0) begin
            if ((n % 2) == 0) acc = acc + (c_CW'(1) << e) / c_CW'(2 * n + 1);
            else              acc = acc - (c_CW'(1) << e) / c_CW'(2 * n + 1);
            n = n + 1;
            e = c_P - i * (2 * n + 1);
        end
        return acc;
    endfunction

    // Entry i of the angle table in z units (2^c_ZW per full turn).
    function automatic logic [c_ZW-1:0] atan_entry(input int i);
        logic [c_CW-1:0] q;
        q = ((atan_pow2(i) << (WIDTH + GUARD - 1)) + (c_PI >> 1)) / c_PI;
        return q[c_ZW-1:0];
    endfunction

    // K * 2^(FRAC+GUARD) via exact product of 1/(1+4^-i) and an integer sqrt.
    function automatic logic [c_XW-1:0] cordic_gain();
        logic [c_CW-1:0] k2;
        logic [c_CW-1:0] n;
        logic [c_CW-1:0] r;
        logic [c_CW-1:0] t;
        int              s;
        k2 = c_CW'(1) << c_P;
        for (int i = 0; i < ITERATIONS; i++) begin
            k2 = k2 - k2 / ((c_CW'(1) << (2 * i)) + c_CW'(1));
        end
        s = 2 * (WIDTH - 2 + GUARD) + 2;
        if (s >= c_P) n = k2 << (s - c_P);
        else          n = k2 >> (c_P - s);
        r = '0;
        for (int b = 99; b >= 0; b--) begin
            t = r | (c_CW'(1) << b);
            if (t * t <= n) r = t;
        end
        r = (r + c_CW'(1)) >> 1;
        return r[c_XW-1:0];
    endfunction

    localparam logic signed [c_XW-1:0] c_X0   = cordic_gain();
    localparam logic        [c_IW-1:0] c_LAST = c_IW'(ITERATIONS - 1);
    localparam logic signed [c_XW:0]   c_HALF = {{c_XW{1'b0}}, 1'b1} << (GUARD - 1);
    localparam logic signed [c_XW:0]   c_MAX  = {{c_XW{1'b0}}, 1'b1} << (WIDTH - 2);
    localparam logic signed [c_XW:0]   c_MIN  = -c_MAX;

    // Drop guard bits with round-half-up, clamp to +/-1.0, then apply the fold sign.
    function automatic logic [WIDTH-1:0] round_sat(input logic signed [c_XW-1:0] v,
                                                   input logic negate);
        logic signed [c_XW:0] t;
        logic signed [c_XW:0] r;
        logic [WIDTH-1:0]     s;
        t = $signed({v[c_XW-1], v}) + c_HALF;
        r = t >>> GUARD;
        if (r > c_MAX)      s = c_MAX[WIDTH-1:0];
        else if (r < c_MIN) s = c_MIN[WIDTH-1:0];
        else                s = r[WIDTH-1:0];
        return negate ? -s : s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [c_XW-1:0]   x_q, x_d;
    logic signed [c_XW-1:0]   y_q, y_d;
    logic signed [c_ZW-1:0]   z_q, z_d;
    logic        [c_IW-1:0]   i_q, i_d;
    logic                     neg_q, neg_d;
    logic                     done_q, done_d;
    logic        [WIDTH-1:0]  sin_q, sin_d;
    logic        [WIDTH-1:0]  cos_q, cos_d;

    logic        [c_ZW-1:0]   atan_tab [ITERATIONS];
    logic signed [c_XW-1:0]   x_sh;
    logic signed [c_XW-1:0]   y_sh;
    logic        [c_ZW-1:0]   atan_cur;
    logic                     fold;
    logic        [WIDTH-1:0]  angle_f;

    for (genvar k = 0; k < ITERATIONS; k++) begin : g_atan
        localparam logic [c_ZW-1:0] c_ATAN = atan_entry(k);
        assign atan_tab[k] = c_ATAN;
    end

    assign x_sh     = x_q >>> i_q;
    assign y_sh     = y_q >>> i_q;
    assign atan_cur = atan_tab[i_q];

    // Second and third quadrants are rotated by pi; the result is negated at the end.
    assign fold    = angle[WIDTH-1] ^ angle[WIDTH-2];
    assign angle_f = {angle[WIDTH-1] ^ fold, angle[WIDTH-2:0]};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        sin_d   = sin_q;
        cos_d   = cos_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d   = fold;
                    z_d     = {angle_f, {GUARD{1'b0}}};
                    x_d     = c_X0;
                    y_d     = '0;
                    i_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!z_q[c_ZW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_cur;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_cur;
                end
                i_d = i_q + 1'b1;
                if (i_q == c_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                sin_d   = round_sat(y_q, neg_q);
                cos_d   = round_sat(x_q, neg_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = done_q;
    assign sin   = sin_q;
    assign cos   = cos_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sincos.sv
`default_nettype none
// ============================================================================
// Module  : tb_cordic_sincos
// Brief   : Directed self-checking bench for cordic_sincos (32-bit, 28 iterations).
// Revision: 1.0
// ============================================================================
module tb_cordic_sincos;

    localparam longint c_ONE = 64'sd1073741824;
    localparam longint c_R2  = 64'sd759250125;
    localparam longint c_S60 = 64'sd929887697;
    localparam longint c_C60 = 64'sd536870912;
    localparam longint c_TOL = 64'sd32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] angle;
    logic        ready;
    logic        done;
    logic [31:0] sin;
    logic [31:0] cos;

    int n_total;
    int n_pass;

    cordic_sincos #(
        .WIDTH      (32),
        .ITERATIONS (28),
        .GUARD      (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .angle (angle),
        .ready (ready),
        .done  (done),
        .sin   (sin),
        .cos   (cos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_total++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol)
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        else
            n_pass++;
    endtask

    function automatic longint sval(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    task automatic run_angle(input string tag, input logic [31:0] a,
                             input longint es, input longint ec);
        int k;
        bit rdy_bad;
        @(negedge clk);
        angle = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        angle   = $urandom;
        k       = 0;
        rdy_bad = 1'b0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
            if (ready) rdy_bad = 1'b1;
        end
        check({tag, "_latency"}, k, 29, 0);
        check({tag, "_busy"}, longint'(rdy_bad), 0, 0);
        check({tag, "_ready"}, longint'(ready), 1, 0);
        check({tag, "_sin"}, sval(sin), es, c_TOL);
        check({tag, "_cos"}, sval(cos), ec, c_TOL);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, longint'(done), 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int     pulses;
        bit     seen;
        longint hs_s [3];
        longint hs_c [3];

        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        angle   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", longint'(ready), 1, 0);
        check("rst_done", longint'(done), 0, 0);
        check("rst_sin", sval(sin), 0, 0);
        check("rst_cos", sval(cos), 0, 0);
        @(negedge clk);
        reset = 1'b0;

        run_angle("a0",     32'h0000_0000, 0,      c_ONE);
        run_angle("pi4",    32'h2000_0000, c_R2,   c_R2);
        run_angle("pi2",    32'h4000_0000, c_ONE,  0);
        check("pi2_sat", longint'(sval(sin) > c_ONE), 0, 0);
        run_angle("pi",     32'h8000_0000, 0,      -c_ONE);
        run_angle("2pi3",   32'h5555_5555, c_S60,  -c_C60);
        run_angle("m_pi3",  32'hD555_5555, -c_S60, c_C60);
        run_angle("m_pi2",  32'hC000_0000, -c_ONE, 0);
        run_angle("3pi4",   32'h6000_0000, c_R2,   -c_R2);
        run_angle("m_3pi4", 32'hA000_0000, -c_R2,  -c_R2);

        // start held high; only angles at cycles 0, 30, 60 are accepted
        hs_s   = '{c_S60, -c_S60, 0};
        hs_c   = '{-c_C60, c_C60, -c_ONE};
        pulses = 0;
        @(negedge clk);
        for (int c = 0; c < 96; c++) begin
            start = (c < 90);
            if (c == 0)       angle = 32'h5555_5555;
            else if (c == 30) angle = 32'hD555_5555;
            else if (c == 60) angle = 32'h8000_0000;
            else              angle = 32'h1000_0000 * ((c % 7) + 1);
            @(posedge clk);
            #1;
            if (done) begin
                if (pulses < 3) begin
                    check("hs_pos", c, 29 + 30 * pulses, 0);
                    check("hs_sin", sval(sin), hs_s[pulses], c_TOL);
                    check("hs_cos", sval(cos), hs_c[pulses], c_TOL);
                end
                pulses++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("hs_count", pulses, 3, 0);

        // asynchronous reset during iteration 10 of an in-flight request
        angle = 32'h5555_5555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_ready", longint'(ready), 1, 0);
        check("arst_done", longint'(done), 0, 0);
        check("arst_sin", sval(sin), 0, 0);
        check("arst_cos", sval(cos), 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("arst_no_done", longint'(seen), 0, 0);
        check("arst_hold_cos", sval(cos), 0, 0);
        run_angle("post_rst", 32'h2000_0000, c_R2, c_R2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
